// File: rtl/float64_pkg.sv
// Shared types and constants for the float64 unpack stage of the DF MUL datapath.
// Class codes, FSM state encodings and a field-level classifier.
// No timing or flow control of its own.
package float64_pkg;

    typedef enum logic [2:0] {
        ZERO      = 3'd0,
        SUBNORMAL = 3'd1,
        NORMAL    = 3'd2,
        INF       = 3'd3,
        QNAN      = 3'd4,
        SNAN      = 3'd5
    } cls_t;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_CLZ   = 4'b0010,
        S_SHIFT = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [51:0] frac;
    } f64_t;

    localparam logic [10:0] EXP_MAX        = 11'd2047;
    localparam int          HIDDEN_BIT     = 52;
    localparam logic [31:0] FLAG_INEXACT   = 32'h1;
    localparam logic [31:0] FLAG_UNDERFLOW = 32'h4;
    localparam logic [31:0] FLAG_OVERFLOW  = 32'h8;
    localparam logic [31:0] FLAG_INVALID   = 32'h10;

    function automatic cls_t classify(input f64_t x);
        cls_t c;
        if (x.exp == 11'd0)
            c = (x.frac == 52'd0) ? ZERO : SUBNORMAL;
        else if (x.exp == EXP_MAX) begin
            if (x.frac == 52'd0)
                c = INF;
            else
                c = x.frac[51] ? QNAN : SNAN;
        end else
            c = NORMAL;
        return c;
    endfunction

endpackage

// File: rtl/clz_chunk.sv
// Leading-zero counter over one W-bit search window.
// Purely combinational, zero latency.
// No flow control; result valid whenever d is stable.
module clz_chunk #(
    parameter int W = 16
) (
    input  logic [W-1:0]         d,
    output logic [$clog2(W):0]   cnt,
    output logic                 all_zero
);

    always_comb begin
        cnt      = ($clog2(W)+1)'(W);
        all_zero = 1'b1;
        for (int k = 0; k < W; k++) begin
            if (all_zero && d[W-1-k]) begin
                cnt      = ($clog2(W)+1)'(k);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/unpack_float64.sv
// Unpacks a binary64 operand into sign, 13-bit signed exponent, 64-bit significand and class.
// Latency 1 for non-subnormals, (chunk+1)+2 for subnormals; optional SNAN flag via FLOAT64_SNAN_FLAG_EN.
// ap_start is only sampled in S_IDLE; a new operand is refused while a search is in flight.
module unpack_float64
    import float64_pkg::*;
#(
    parameter int CHUNK_W = 16
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    output logic        z_sign,
    output logic [12:0] z_exp,
    output logic [63:0] z_sig,
    output logic [2:0]  z_class
`ifdef FLOAT64_SNAN_FLAG_EN
    ,
    input  logic [31:0] float_exception_flag_i,
    output logic [31:0] float_exception_flag_o,
    output logic        float_exception_flag_o_ap_vld
`endif
);

    localparam int NCH = 64 / CHUNK_W;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(CHUNK_W) + 1;

    state_t          state;
    f64_t            op_q;
    logic [IW-1:0]   idx;
    logic [6:0]      lz_q;

    f64_t            a_f;
    cls_t            a_cls;
    logic [63:0]     srch_w;
    logic [6:0]      base;
    logic [6:0]      top;
    logic [CHUNK_W-1:0] chunk;
    logic [CW-1:0]   cnt;
    logic            all_zero;
    logic [5:0]      sc;

    assign a_f   = a;
    assign a_cls = classify(a_f);

    // Fraction is left-justified in the search word, so a leading-zero count
    // of lz puts the top set bit at f[51-lz]; lifting it to bit 52 needs lz+1.
    assign srch_w = {op_q.frac, 12'b0};
    assign base   = 7'(idx) * 7'(CHUNK_W);
    assign top    = 7'd63 - base;
    assign chunk  = srch_w[top -: CHUNK_W];
    assign sc     = 6'(lz_q + 7'd1);

    clz_chunk #(.W(CHUNK_W)) u_clz (
        .d        (chunk),
        .cnt      (cnt),
        .all_zero (all_zero)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= S_IDLE;
            op_q    <= '0;
            idx     <= '0;
            lz_q    <= '0;
            z_sign  <= 1'b0;
            z_exp   <= '0;
            z_sig   <= '0;
            z_class <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        op_q <= a_f;
                        idx  <= '0;
                        if (a_cls == SUBNORMAL) begin
                            state <= S_CLZ;
                        end else begin
                            z_sign  <= a_f.sign;
                            z_class <= a_cls;
                            state   <= S_DONE;
                            case (a_cls)
                                ZERO: begin
                                    z_exp <= '0;
                                    z_sig <= '0;
                                end
                                NORMAL: begin
                                    z_exp <= {2'b00, a_f.exp};
                                    z_sig <= {11'b0, 1'b1, a_f.frac};
                                end
                                default: begin
                                    z_exp <= {2'b00, EXP_MAX};
                                    z_sig <= {12'b0, a_f.frac};
                                end
                            endcase
                        end
                    end
                end
                S_CLZ: begin
                    if (!all_zero) begin
                        lz_q  <= base + 7'(cnt);
                        state <= S_SHIFT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_SHIFT: begin
                    z_sign  <= op_q.sign;
                    z_sig   <= {12'b0, op_q.frac} << sc;
                    z_exp   <= 13'd1 - {7'b0, sc};
                    z_class <= SUBNORMAL;
                    state   <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ap_done  = (state == S_DONE);
    assign ap_ready = ap_done;
    assign ap_idle  = (state == S_IDLE) && !ap_start;

`ifdef FLOAT64_SNAN_FLAG_EN
    logic snan_done;
    assign snan_done = ap_done && (z_class == SNAN);
    assign float_exception_flag_o        = snan_done ? (float_exception_flag_i | FLAG_INVALID)
                                                     : float_exception_flag_i;
    assign float_exception_flag_o_ap_vld = snan_done;
`endif

endmodule
